// File: rtl/neural_layer_seq.sv
// neural_layer_seq: time-multiplexed fully connected layer with one shared MAC.
// N_OUT neurons x N_IN inputs, signed fixed point with FRAC fractional bits.
// Each result is shifted right by FRAC, then saturated to WIDTH bits.
// Optional macro NEURAL_LAYER_RELU_EN clamps negative results to zero.
module neural_layer_seq #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned FRAC  = WIDTH / 2,
  parameter int unsigned N_IN  = 2,
  parameter int unsigned N_OUT = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [N_IN*WIDTH-1:0]         in_data,
  input  logic [N_OUT*N_IN*WIDTH-1:0]   in_coeff,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [N_OUT*WIDTH-1:0]        out_data,
  output logic                          busy
);

  // Extra bits so the sum of N_IN full-width products cannot overflow.
  localparam int unsigned AW = 2 * WIDTH + $clog2(N_IN) + 1;
  localparam int unsigned IW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int unsigned JW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  localparam logic [IW-1:0] ILast = IW'(N_IN - 1);
  localparam logic [JW-1:0] JLast = JW'(N_OUT - 1);

  localparam logic signed [AW-1:0] MaxV = {{(AW - WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
  localparam logic signed [AW-1:0] MinV = {{(AW - WIDTH + 1){1'b1}}, {(WIDTH - 1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StMac, StDone} state_e;

  state_e                        state_q, state_d;
  logic                          started_q;
  logic [N_IN*WIDTH-1:0]         x_q;
  logic [N_OUT*N_IN*WIDTH-1:0]   w_q;
  logic signed [AW-1:0]          acc_q;
  logic [IW-1:0]                 i_q;
  logic [JW-1:0]                 j_q;
  logic [N_OUT*WIDTH-1:0]        out_q;

  logic                          accept;
  logic                          last_i;
  logic signed [WIDTH-1:0]       x_cur, w_cur;
  logic signed [2*WIDTH-1:0]     prod;
  logic signed [AW-1:0]          sum, shifted;
  logic [WIDTH-1:0]              res;

  // started_q keeps in_ready low until the first clock after reset release.
  assign in_ready  = started_q && (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q == StMac);
  assign out_data  = out_q;
  assign accept    = in_valid && in_ready;
  assign last_i    = (i_q == ILast);

  assign x_cur = x_q[i_q * WIDTH +: WIDTH];
  assign w_cur = w_q[(j_q * N_IN + i_q) * WIDTH +: WIDTH];
  // Sign-extend both operands so the low 2*WIDTH product bits are the exact signed product.
  assign prod    = {{WIDTH{x_cur[WIDTH-1]}}, x_cur} * {{WIDTH{w_cur[WIDTH-1]}}, w_cur};
  assign sum     = acc_q + {{(AW - 2 * WIDTH){prod[2*WIDTH-1]}}, prod};
  assign shifted = sum >>> FRAC;

  // Saturate the scaled sum to WIDTH bits, then apply the activation.
  always_comb begin
    res = shifted[WIDTH-1:0];
    if (shifted > MaxV) begin
      res = MaxV[WIDTH-1:0];
    end else if (shifted < MinV) begin
      res = MinV[WIDTH-1:0];
    end
`ifdef NEURAL_LAYER_RELU_EN
    if (res[WIDTH-1]) begin
      res = '0;
    end
`endif
  end

  // State register and post-reset ready enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      started_q <= 1'b1;
    end
  end

  // Next-state logic: IDLE -> MAC -> DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StMac;
      StMac:   if (last_i && (j_q == JLast)) state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Capture, accumulate and write back one neuron result per N_IN cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q   <= '0;
      w_q   <= '0;
      acc_q <= '0;
      i_q   <= '0;
      j_q   <= '0;
      out_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            x_q   <= in_data;
            w_q   <= in_coeff;
            acc_q <= '0;
            i_q   <= '0;
            j_q   <= '0;
          end
        end
        StMac: begin
          if (last_i) begin
            out_q[j_q * WIDTH +: WIDTH] <= res;
            acc_q <= '0;
            i_q   <= '0;
            if (j_q != JLast) begin
              j_q <= j_q + 1'b1;
            end
          end else begin
            acc_q <= sum;
            i_q   <= i_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_neural_layer_seq.sv
// Scoreboard bench for neural_layer_seq (defaults: Q8.8, 2 inputs, 2 neurons).
// Honours NEURAL_LAYER_RELU_EN in its reference model.
module tb_neural_layer_seq;

  localparam int unsigned W     = 16;
  localparam int unsigned FR    = 8;
  localparam int unsigned NI    = 2;
  localparam int unsigned NO    = 2;
  localparam int unsigned LAT   = NI * NO;

  typedef logic [NI*W-1:0]    xvec_t;
  typedef logic [NO*NI*W-1:0] wvec_t;
  typedef logic [NO*W-1:0]    ovec_t;

  logic  clk = 1'b0;
  logic  rst_n;
  logic  in_valid;
  logic  in_ready;
  xvec_t in_data;
  wvec_t in_coeff;
  logic  out_valid;
  logic  out_ready;
  ovec_t out_data;
  logic  busy;

  int    n_checks = 0;
  int    n_fail   = 0;
  ovec_t sb[$];
  ovec_t exp_cur;

  neural_layer_seq #(
    .WIDTH (W),
    .FRAC  (FR),
    .N_IN  (NI),
    .N_OUT (NO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_coeff  (in_coeff),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: exact dot product, floor shift, clamp to signed W, optional ReLU.
  function automatic ovec_t model(input xvec_t x, input wvec_t w);
    ovec_t r;
    longint s, mx, mn;
    logic signed [W-1:0] xv, wv;
    mx = (longint'(1) <<< (W - 1)) - 1;
    mn = -(longint'(1) <<< (W - 1));
    r = '0;
    for (int j = 0; j < NO; j++) begin
      s = 0;
      for (int i = 0; i < NI; i++) begin
        xv = x[i*W +: W];
        wv = w[(j*NI + i)*W +: W];
        s += longint'(xv) * longint'(wv);
      end
      s = s >>> FR;
      if (s > mx) s = mx;
      if (s < mn) s = mn;
`ifdef NEURAL_LAYER_RELU_EN
      if (s < 0) s = 0;
`endif
      r[j*W +: W] = W'(s);
    end
    return r;
  endfunction

  // Monitor: every output handshake consumes one scoreboard entry.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_output", 64'(out_data), 64'hDEAD);
      end else begin
        chk("sb_out_data", 64'(out_data), 64'(sb.pop_front()));
      end
    end
  end

  // Present a vector, wait (bounded) for in_ready, return just after the accept edge.
  task automatic send(input xvec_t x, input wvec_t w);
    int cnt = 0;
    in_data  = x;
    in_coeff = w;
    in_valid = 1'b1;
    while (!in_ready && cnt < 50) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("in_ready_wait", 64'(in_ready), 64'd1);
    exp_cur = model(x, w);
    sb.push_back(exp_cur);
    @(posedge clk); #1;
  endtask

  // Full transaction: latency, MAC-phase checks, backpressure for 'hold' cycles, handshake.
  task automatic run_vec(input xvec_t x, input wvec_t w, input int hold);
    int lat = 0;
    send(x, w);
    // in_valid stays high with changing data to show it is ignored while busy
    while (!out_valid && lat < 50) begin
      chk("busy_in_mac", 64'(busy), 64'd1);
      chk("in_ready_in_mac", 64'(in_ready), 64'd0);
      in_data = xvec_t'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'(LAT));
    for (int k = 0; k < hold; k++) begin
      chk("hold_out_data", 64'(out_data), 64'(exp_cur));
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      chk("hold_out_valid", 64'(out_valid), 64'd1);
      in_data  = xvec_t'($urandom);
      in_coeff = {$urandom, $urandom};
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("out_valid_after_hs", 64'(out_valid), 64'd0);
    chk("in_ready_after_hs", 64'(in_ready), 64'd1);
    chk("busy_after_hs", 64'(busy), 64'd0);
    out_ready = 1'b0;
  endtask

  function automatic logic [W-1:0] rnd_word();
    logic [W-1:0] v;
    v = W'($urandom);
    // mix full-range words with small ones near 1.0 so both saturation and normal paths occur
    if ($urandom_range(0, 1) == 0) v = W'($signed(v) >>> 6);
    return v;
  endfunction

  initial begin
    xvec_t x;
    wvec_t w;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    in_coeff  = '0;

    #12;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("in_ready_before_clk", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    chk("in_ready_after_release", 64'(in_ready), 64'd1);

    // Basic MAC, with 10 cycles of backpressure
    run_vec({16'h0200, 16'h0100}, {16'h0100, 16'h0040, 16'h0080, 16'h0100}, 10);
    // Positive saturation
    run_vec({16'h7F00, 16'h7F00}, {4{16'h7F00}}, 1);
    // Negative saturation
    run_vec({16'h8000, 16'h8000}, {4{16'h7F00}}, 0);
    // Negative value with truncated fractional part
    run_vec({16'h0001, 16'h0100}, {16'h0000, 16'h0000, 16'h0080, 16'hFF00}, 2);

    // Reset two cycles after accept: abort and discard
    send({16'h1234, 16'h0456}, {16'h0100, 16'h0200, 16'h0300, 16'h0400});
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out_data", 64'(out_data), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_midrst", 64'(in_ready), 64'd1);
    run_vec({16'h0100, 16'h0100}, {4{16'h0100}}, 0);

    // Randomised vectors with random backpressure
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < NI; i++) x[i*W +: W] = rnd_word();
      for (int k = 0; k < NI*NO; k++) w[k*W +: W] = rnd_word();
      run_vec(x, w, int'($urandom_range(0, 3)));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
